// File: rtl/rom_fetch_engine.sv
// Sequential ROM fetch engine: issues addresses, absorbs the ROM's one-cycle read
// latency, and buffers {addr, data} bytes in a prefetch FIFO with a valid/ready head.
module rom_fetch_engine #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  ENABLE,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   inflight_valid_q, inflight_valid_d;
  logic [ADDR_WIDTH-1:0]  inflight_addr_q, inflight_addr_d;
  logic [ADDR_WIDTH-1:0]  addr_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic credit_ok_c;
  logic issue_c;
  logic push_c;
  logic pop_c;

  // Conservative credit: an in-flight byte reserves a slot, a same-cycle pop frees none.
  assign credit_ok_c = (count_q + CNT_W'(inflight_valid_q)) < CNT_W'(FIFO_DEPTH);
  assign push_c      = inflight_valid_q && !JUMP;
  assign pop_c       = INSTR_VALID && INSTR_READY;

  assign ROM_ADDR    = fetch_pc_q;
  assign INSTR       = data_mem_q[rd_ptr_q];
  assign INSTR_ADDR  = addr_mem_q[rd_ptr_q];
  assign INSTR_VALID = (count_q != '0);

  // FSM state register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ENABLE) state_d = S_FETCH;
      S_FETCH: if (!credit_ok_c) state_d = S_STALL;
      S_STALL: if (credit_ok_c) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (!ENABLE) state_d = S_IDLE;
  end

  // FSM output: issue gating; the state itself only tracks it
  always_comb begin
    issue_c = 1'b0;
    if (ENABLE && !JUMP && credit_ok_c) issue_c = 1'b1;
  end

  // Fetch pointer, in-flight tracking and FIFO next state; JUMP overrides everything
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = 1'b0;
    inflight_addr_d  = inflight_addr_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    addr_mem_d       = addr_mem_q;
    data_mem_d       = data_mem_q;

    if (JUMP) begin
      fetch_pc_d = JUMP_ADDR;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (issue_c) begin
        inflight_valid_d = 1'b1;
        inflight_addr_d  = fetch_pc_q;
        fetch_pc_d       = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (push_c) begin
        addr_mem_d[wr_ptr_q] = inflight_addr_q;
        data_mem_d[wr_ptr_q] = ROM_DATA;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      fetch_pc_q       <= RESET_VECTOR;
      inflight_valid_q <= 1'b0;
      inflight_addr_q  <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_addr_q  <= inflight_addr_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      addr_mem_q       <= addr_mem_d;
      data_mem_q       <= data_mem_d;
    end
  end

endmodule

// File: tb/tb_rom_fetch_engine.sv
// Directed bench for rom_fetch_engine: vector table plus hand-written ENABLE-drop
// and reset-while-full sequences; ROM content is addr ^ 8'hA5.
module tb_rom_fetch_engine;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic       jmp;
  logic [7:0] jaddr;

  logic [7:0] rom_addr, rom_data, instr, instr_addr;
  logic       valid;
  logic [7:0] fe_rom_addr, fe_rom_data, fe_instr, fe_instr_addr;
  logic       fe_valid;

  int n_cmp;
  int n_err;

  rom_fetch_engine u_dut (
    .CLK        (clk),
    .RESETN     (rst_n),
    .ENABLE     (en),
    .ROM_ADDR   (rom_addr),
    .ROM_DATA   (rom_data),
    .JUMP       (jmp),
    .JUMP_ADDR  (jaddr),
    .INSTR      (instr),
    .INSTR_ADDR (instr_addr),
    .INSTR_VALID(valid),
    .INSTR_READY(rdy)
  );

  rom_fetch_engine #(.RESET_VECTOR(8'hFE)) u_dut_fe (
    .CLK        (clk),
    .RESETN     (rst_n),
    .ENABLE     (en),
    .ROM_ADDR   (fe_rom_addr),
    .ROM_DATA   (fe_rom_data),
    .JUMP       (jmp),
    .JUMP_ADDR  (jaddr),
    .INSTR      (fe_instr),
    .INSTR_ADDR (fe_instr_addr),
    .INSTR_VALID(fe_valid),
    .INSTR_READY(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM models
  always_ff @(posedge clk) begin
    rom_data    <= rom_addr ^ 8'hA5;
    fe_rom_data <= fe_rom_addr ^ 8'hA5;
  end

  typedef struct packed {
    logic       en;
    logic       rdy;
    logic       jmp;
    logic [7:0] jaddr;
    logic       exp_valid;
    logic [7:0] exp_addr;
    logic [7:0] exp_instr;
    logic [7:0] exp_rom;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  logic [7:0] fe_exp_addr  [4];
  logic [7:0] fe_exp_instr [4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_next;
    int         cyc;

    n_cmp = 0;
    n_err = 0;

    //            en    rdy   jmp   jaddr  valid addr   instr  rom_addr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'hA5, 8'h02};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'hA4, 8'h03};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'hA7, 8'h04};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h05};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h06};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h07};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h07};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h07};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'hA1, 8'h07};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 8'hA0, 8'h08};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 8'hA3, 8'h09};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 8'hA2, 8'h0A};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 8'hAD, 8'h0B};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 8'h40};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h41};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 8'hE5, 8'h42};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 8'hE4, 8'h43};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 8'hE7, 8'h44};

    fe_exp_addr[0]  = 8'hFE; fe_exp_instr[0] = 8'h5B;
    fe_exp_addr[1]  = 8'hFF; fe_exp_instr[1] = 8'h5A;
    fe_exp_addr[2]  = 8'h00; fe_exp_instr[2] = 8'hA5;
    fe_exp_addr[3]  = 8'h01; fe_exp_instr[3] = 8'hA4;

    rst_n = 1'b0;
    en    = 1'b1;
    rdy   = 1'b1;
    jmp   = 1'b0;
    jaddr = 8'h00;

    #12;
    check("reset valid",      8'(valid), 8'h00);
    check("reset instr",      instr,      8'h00);
    check("reset instr_addr", instr_addr, 8'h00);
    check("reset rom_addr",   rom_addr,   8'h00);
    check("reset fe rom_addr", fe_rom_addr, 8'hFE);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      en    = vecs[i].en;
      rdy   = vecs[i].rdy;
      jmp   = vecs[i].jmp;
      jaddr = vecs[i].jaddr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 8'(valid), 8'(vecs[i].exp_valid));
      check($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].exp_rom);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d instr_addr", i), instr_addr, vecs[i].exp_addr);
        check($sformatf("v%0d instr", i), instr, vecs[i].exp_instr);
      end
      if (i >= 1 && i <= 4) begin
        check($sformatf("fe v%0d valid", i), 8'(fe_valid), 8'h01);
        check($sformatf("fe v%0d instr_addr", i), fe_instr_addr, fe_exp_addr[i-1]);
        check($sformatf("fe v%0d instr", i), fe_instr, fe_exp_instr[i-1]);
      end
    end
    jmp = 1'b0;

    // ENABLE low for 5 cycles with INSTR_READY toggling; stream must stay in order
    exp_next = 8'h42;
    cyc      = 0;
    while (exp_next != 8'h50 && cyc < 200) begin
      en  = (cyc >= 5);
      rdy = (cyc % 2 == 0);
      if (valid && rdy) begin
        check($sformatf("drain addr c%0d", cyc), instr_addr, exp_next);
        check($sformatf("drain instr c%0d", cyc), instr, exp_next ^ 8'hA5);
        exp_next = exp_next + 8'h01;
      end
      @(posedge clk);
      #1;
      if (cyc < 5) check($sformatf("frozen rom_addr c%0d", cyc), rom_addr, 8'h44);
      cyc++;
    end
    check("drain reached end", exp_next, 8'h50);

    // Fill the FIFO, then pulse reset asynchronously mid-cycle
    en  = 1'b1;
    rdy = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("full valid", 8'(valid), 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst valid",      8'(valid), 8'h00);
    check("async rst rom_addr",   rom_addr,   8'h00);
    check("async rst instr",      instr,      8'h00);
    check("async rst instr_addr", instr_addr, 8'h00);
    check("async rst fe rom_addr", fe_rom_addr, 8'hFE);
    #1;
    rst_n = 1'b1;
    rdy   = 1'b1;
    @(posedge clk);
    #1;
    check("restart p0 valid",    8'(valid), 8'h00);
    check("restart p0 rom_addr", rom_addr,  8'h01);
    @(posedge clk);
    #1;
    check("restart p1 valid",      8'(valid), 8'h01);
    check("restart p1 instr_addr", instr_addr, 8'h00);
    check("restart p1 instr",      instr,      8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
